// File: rtl/hyper_align_arbiter.sv
// Round-robin alignment arbiter for four LSAB requesters. It opens a DRAM page through a
// toggle handshake with the MCU and interleaves scheduler refreshes, which take priority.
module hyper_align_arbiter #(
  parameter logic [7:0] OPEN_TIMEOUT = 8'd200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [79:0] PAGE_ADDR,
  output logic [3:0]  GRANT,
  input  logic        REFRESH_PULSE,
  output logic [19:0] MCU_PAGE_ADDR,
  output logic        MCU_OPEN,
  input  logic        MCU_OPEN_ACK,
  output logic        MCU_REFRESH_STROBE,
  input  logic        MCU_REFRESH_ACK,
  output logic        BUSY,
  output logic        TIMEOUT_ERR,
  output logic        RFRS_OVERFLOW
);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_HOLD, S_REFRESH} state_t;

  state_t      state;
  logic [1:0]  pending;
  logic [1:0]  last;
  logic [1:0]  cur;
  logic [7:0]  tcnt;
  logic [1:0]  pick;
  logic        pick_valid;
  logic [19:0] page_sel;
  logic        open_idle;
  logic        rfrs_done;
  logic        rfrs_want;

  // Scan from last+1 around to last itself; first requester found wins.
  always_comb begin
    pick       = last;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!pick_valid && REQ[last + 2'(k)]) begin
        pick       = last + 2'(k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    case (pick)
      2'd0:    page_sel = PAGE_ADDR[19:0];
      2'd1:    page_sel = PAGE_ADDR[39:20];
      2'd2:    page_sel = PAGE_ADDR[59:40];
      default: page_sel = PAGE_ADDR[79:60];
    endcase
  end

  assign open_idle = (MCU_OPEN == MCU_OPEN_ACK);
  assign rfrs_done = (state == S_REFRESH) && (MCU_REFRESH_ACK == MCU_REFRESH_STROBE);
  // A pulse arriving in IDLE is served before any requester sampled on the same edge.
  assign rfrs_want = (pending != 2'd0) || REFRESH_PULSE;
  assign BUSY      = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state              <= S_IDLE;
      GRANT              <= '0;
      MCU_PAGE_ADDR      <= '0;
      MCU_OPEN           <= 1'b0;
      MCU_REFRESH_STROBE <= 1'b0;
      pending            <= '0;
      last               <= 2'd3;
      cur                <= '0;
      tcnt               <= '0;
      TIMEOUT_ERR        <= 1'b0;
      RFRS_OVERFLOW      <= 1'b0;
    end else begin
      case ({REFRESH_PULSE, rfrs_done})
        2'b10: begin
          if (pending == 2'd3) RFRS_OVERFLOW <= 1'b1;
          else                 pending       <= pending + 2'd1;
        end
        2'b01:   pending <= pending - 2'd1;
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (rfrs_want) begin
            MCU_REFRESH_STROBE <= ~MCU_REFRESH_STROBE;
            state              <= S_REFRESH;
          end else if (pick_valid && open_idle) begin
            cur           <= pick;
            last          <= pick;
            MCU_PAGE_ADDR <= page_sel;
            MCU_OPEN      <= ~MCU_OPEN;
            tcnt          <= '0;
            state         <= S_OPEN;
          end
        end
        S_OPEN: begin
          if (MCU_OPEN_ACK == MCU_OPEN) begin
            if (REQ[cur]) begin
              GRANT <= 4'b0001 << cur;
              state <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
            if (tcnt + 8'd1 == OPEN_TIMEOUT) begin
              TIMEOUT_ERR <= 1'b1;
              state       <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (!REQ[cur]) begin
            GRANT <= '0;
            state <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (rfrs_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_align_arbiter.sv
// Bench for hyper_align_arbiter: directed scenarios plus a randomized phase, checked against
// a transaction-level model with a toggle-handshake MCU responder.
module tb_hyper_align_arbiter;

  localparam logic [7:0] TMO = 8'd10;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [79:0] PAGE_ADDR;
  logic [3:0]  GRANT;
  logic        REFRESH_PULSE;
  logic [19:0] MCU_PAGE_ADDR;
  logic        MCU_OPEN;
  logic        MCU_OPEN_ACK;
  logic        MCU_REFRESH_STROBE;
  logic        MCU_REFRESH_ACK;
  logic        BUSY;
  logic        TIMEOUT_ERR;
  logic        RFRS_OVERFLOW;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 CLK = ~CLK;

  hyper_align_arbiter #(.OPEN_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .PAGE_ADDR(PAGE_ADDR), .GRANT(GRANT),
    .REFRESH_PULSE(REFRESH_PULSE), .MCU_PAGE_ADDR(MCU_PAGE_ADDR), .MCU_OPEN(MCU_OPEN),
    .MCU_OPEN_ACK(MCU_OPEN_ACK), .MCU_REFRESH_STROBE(MCU_REFRESH_STROBE),
    .MCU_REFRESH_ACK(MCU_REFRESH_ACK), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR),
    .RFRS_OVERFLOW(RFRS_OVERFLOW)
  );

  // MCU responder knobs and observation state
  bit          open_en = 1'b1, rfrs_en = 1'b1;
  int unsigned open_dly = 2, rfrs_dly = 2, open_wait = 0, rfrs_wait = 0;
  int unsigned cyc = 0, open_tgl = 0, rfrs_tgl = 0, grants = 0;
  int unsigned ack_cyc = 0, rack_cyc = 0, open_cyc = 0, grant_cyc = 0;
  int unsigned m_last = 3, m_cur = 0;
  logic        prev_open = 1'b0, prev_oack = 1'b0, prev_strb = 1'b0, prev_rack = 1'b0;
  logic [3:0]  prev_grant = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [3:0] req, input int unsigned from);
    for (int unsigned k = 1; k <= 4; k++)
      if (req[(from + k) % 4]) return (from + k) % 4;
    return from;
  endfunction

  function automatic int unsigned grant_idx(input logic [3:0] g);
    for (int unsigned i = 0; i < 4; i++) if (g[i]) return i;
    return 99;
  endfunction

  // One clock: sample #1 after the edge, run the checks, then let the MCU respond.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      if (MCU_OPEN !== prev_open) begin
        open_tgl++;
        open_cyc = cyc;
        chk("open_waits_ack", prev_open, prev_oack);
        m_cur  = rr_pick(REQ, m_last);
        m_last = m_cur;
        chk("open_page", MCU_PAGE_ADDR, PAGE_ADDR[m_cur*20 +: 20]);
      end
      if (MCU_REFRESH_STROBE !== prev_strb) begin
        rfrs_tgl++;
        chk("strobe_waits_ack", prev_strb, prev_rack);
      end
      chk("grant_onehot", $countones(GRANT) <= 1, 1);
      if (!BUSY) chk("grant_zero_idle", GRANT, 0);
      if (prev_grant != 0) begin
        chk("hold_grant", GRANT, ((REQ & prev_grant) != 0) ? prev_grant : 4'b0000);
        chk("hold_no_strobe", MCU_REFRESH_STROBE, prev_strb);
      end else if (GRANT != 0) begin
        grants++;
        grant_cyc = cyc;
        chk("grant_index", GRANT, 4'b0001 << m_cur);
        chk("grant_req_held", REQ[m_cur], 1);
        chk("grant_after_ack", prev_oack, MCU_OPEN);
      end
      if (MCU_OPEN !== MCU_OPEN_ACK) begin
        open_wait++;
        if (open_en && open_wait >= open_dly) begin
          MCU_OPEN_ACK = MCU_OPEN;
          open_wait    = 0;
          ack_cyc      = cyc;
        end
      end else open_wait = 0;
      if (MCU_REFRESH_STROBE !== MCU_REFRESH_ACK) begin
        rfrs_wait++;
        if (rfrs_en && rfrs_wait >= rfrs_dly) begin
          MCU_REFRESH_ACK = MCU_REFRESH_STROBE;
          rfrs_wait       = 0;
          rack_cyc        = cyc;
        end
      end else rfrs_wait = 0;
    end else begin
      MCU_OPEN_ACK    = 1'b0;
      MCU_REFRESH_ACK = 1'b0;
      open_wait       = 0;
      rfrs_wait       = 0;
      m_last          = 3;
    end
    prev_open  = MCU_OPEN;
    prev_oack  = MCU_OPEN_ACK;
    prev_strb  = MCU_REFRESH_STROBE;
    prev_rack  = MCU_REFRESH_ACK;
    prev_grant = GRANT;
  endtask

  task automatic wait_grant(input string tag, input int unsigned budget);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (GRANT != 0);
    end
    chk(tag, ok, 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s_exp;
    int unsigned t0, o0, r0, g0, pulses, idx;
    RST = 1'b0; REQ = '0; REFRESH_PULSE = 1'b0;
    PAGE_ADDR = {$urandom, $urandom, $urandom};
    MCU_OPEN_ACK = 1'b0; MCU_REFRESH_ACK = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {GRANT, MCU_PAGE_ADDR, MCU_OPEN, MCU_REFRESH_STROBE, BUSY,
                          TIMEOUT_ERR, RFRS_OVERFLOW}, 0);
    RST = 1'b1;
    tick();

    // Single request, MCU acks three cycles after the open toggle
    PAGE_ADDR = {$urandom, $urandom, 12'h0, 20'hABCDE};
    open_dly = 3; o0 = open_tgl; t0 = cyc;
    REQ = 4'b0001;
    wait_grant("sr_wait", 30);
    chk("sr_grant", GRANT, 4'b0001);
    chk("sr_page", MCU_PAGE_ADDR, 20'hABCDE);
    chk("sr_open_toggles", open_tgl - o0, 1);
    chk("sr_grant_after_ack", grant_cyc, ack_cyc + 1);
    chk("sr_latency", grant_cyc - t0, 4);
    tick(); tick();
    REQ = 4'b0000;
    tick();
    chk("sr_release_grant", GRANT, 0);
    chk("sr_release_busy", BUSY, 0);

    // Minimum latency: ack returned one cycle after the toggle
    open_dly = 1; t0 = cyc;
    REQ = 4'b0100;
    wait_grant("lat_wait", 10);
    chk("lat_grant", GRANT, 4'b0100);
    chk("lat_cycles", grant_cyc - t0, 2);
    REQ = 4'b0000;
    tick(); tick();

    // Round robin with all four requesting from reset
    do_reset();
    open_dly = 2;
    REQ = 4'b1111;
    for (int unsigned n = 0; n < 5; n++) begin
      wait_grant("rr_wait", 30);
      idx = grant_idx(GRANT);
      chk("rr_order", idx, n % 4);
      repeat (4) tick();
      REQ[idx] = 1'b0;
      tick();
      REQ[idx] = 1'b1;
    end
    REQ = 4'b0000;
    repeat (8) tick();

    // Refresh wins over a request raised on the same edge
    rfrs_dly = 3; o0 = open_tgl; s_exp = ~MCU_REFRESH_STROBE;
    REFRESH_PULSE = 1'b1; REQ = 4'b0010;
    tick();
    REFRESH_PULSE = 1'b0;
    chk("rp_strobe_first", MCU_REFRESH_STROBE, s_exp);
    chk("rp_no_open", open_tgl - o0, 0);
    wait_grant("rp_wait", 40);
    chk("rp_grant", GRANT, 4'b0010);
    chk("rp_after_rack", grant_cyc > rack_cyc, 1);
    REQ = 4'b0000;
    repeat (4) tick();

    // Four pulses during a long hold: one lost, three served afterwards
    REQ = 4'b0100;
    wait_grant("ov_wait", 30);
    chk("ov_grant", GRANT, 4'b0100);
    r0 = rfrs_tgl;
    repeat (4) begin
      REFRESH_PULSE = 1'b1;
      tick();
      REFRESH_PULSE = 1'b0;
      tick();
    end
    chk("ov_flag", RFRS_OVERFLOW, 1);
    chk("ov_no_strobe_in_hold", rfrs_tgl - r0, 0);
    chk("ov_grant_kept", GRANT, 4'b0100);
    rfrs_dly = 2;
    REQ = 4'b0000;
    repeat (40) tick();
    chk("ov_strobes", rfrs_tgl - r0, 3);
    chk("ov_idle", BUSY, 0);

    // Open timeout with no ack, then a late ack
    open_en = 1'b0;
    REQ = 4'b0001;
    tick();
    t0 = open_cyc;
    for (int unsigned i = 0; i < 30 && !TIMEOUT_ERR; i++) tick();
    chk("to_flag", TIMEOUT_ERR, 1);
    chk("to_cycles", cyc - t0, TMO);
    chk("to_idle", BUSY, 0);
    chk("to_no_grant", GRANT, 0);
    o0 = open_tgl;
    repeat (15) tick();
    chk("to_no_reopen", open_tgl - o0, 0);
    chk("to_still_idle", BUSY, 0);
    open_en = 1'b1; open_dly = 1;
    wait_grant("to_late_wait", 20);
    chk("to_late_grant", GRANT, 4'b0001);
    chk("to_reopen", open_tgl - o0, 1);
    chk("to_sticky", TIMEOUT_ERR, 1);
    REQ = 4'b0000;
    repeat (3) tick();

    // Reset in the middle of a hold
    REQ = 4'b0100;
    wait_grant("rh_wait", 20);
    chk("rh_grant", GRANT, 4'b0100);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("rh_reset_outputs", {GRANT, MCU_PAGE_ADDR, MCU_OPEN, MCU_REFRESH_STROBE, BUSY,
                             TIMEOUT_ERR, RFRS_OVERFLOW}, 0);
    wait_grant("rh_resume_wait", 20);
    chk("rh_resume_grant", GRANT, 4'b0100);
    REQ = 4'b0000;
    repeat (3) tick();

    // Randomized traffic; pulses are spaced so the pending counter cannot saturate
    do_reset();
    r0 = rfrs_tgl; g0 = grants; pulses = 0;
    for (int unsigned it = 0; it < 1500; it++) begin
      open_dly  = $urandom_range(5, 1);
      rfrs_dly  = $urandom_range(5, 1);
      PAGE_ADDR = {$urandom, $urandom, $urandom};
      if ($urandom_range(5) == 0) REQ[$urandom_range(3)] = ~REQ[$urandom_range(3)];
      if ($urandom_range(19) == 0 && (pulses - (rfrs_tgl - r0)) <= 1) begin
        REFRESH_PULSE = 1'b1;
        pulses++;
      end
      tick();
      REFRESH_PULSE = 1'b0;
    end
    REQ = 4'b0000;
    repeat (40) tick();
    chk("rnd_strobes", rfrs_tgl - r0, pulses);
    chk("rnd_overflow", RFRS_OVERFLOW, 0);
    chk("rnd_timeout", TIMEOUT_ERR, 0);
    chk("rnd_idle", BUSY, 0);
    chk("rnd_grants_seen", (grants - g0) > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyper_align_arbiter.md
HYPER_ALIGN_ARBITER -- requirements
Module: hyper_align_arbiter

Interface
REQ-001 The block SHALL have parameter OPEN_TIMEOUT, default 8'd200: the maximum number of cycles spent in OPEN waiting for the MCU acknowledge.
REQ-002 CLK  in  1  system clock; all state SHALL update on its posedge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 REQ  in  4  per-LSAB alignment request, level, held for the whole transfer.
REQ-005 PAGE_ADDR  in  80  four 20-bit DRAM page addresses; requester i uses [20i+19:20i].
REQ-006 GRANT  out  4  one-hot alignment grant, registered.
REQ-007 REFRESH_PULSE  in  1  single-cycle refresh request from the scheduler.
REQ-008 MCU_PAGE_ADDR  out  20  page to open, registered.
REQ-009 MCU_OPEN  out  1  toggle strobe; each edge requests a page open.
REQ-010 MCU_OPEN_ACK  in  1  toggle; equals MCU_OPEN when the open is done.
REQ-011 MCU_REFRESH_STROBE  out  1  toggle strobe; each edge requests a refresh.
REQ-012 MCU_REFRESH_ACK  in  1  toggle; equals MCU_REFRESH_STROBE when the refresh is done.
REQ-013 BUSY  out  1  high whenever the state is not IDLE.
REQ-014 TIMEOUT_ERR  out  1  sticky; set when an open times out.
REQ-015 RFRS_OVERFLOW  out  1  sticky; set when a refresh request is lost.

Function
REQ-016 The FSM SHALL have the states IDLE, OPEN, HOLD and REFRESH, state-encoded in registers.
REQ-017 Refresh pending counter (2-bit, saturating):
- +1 on REFRESH_PULSE.
- -1 when REFRESH completes.
- Simultaneous pulse and completion: net unchanged.
- Pulse while the count is 3 and no completion: count stays 3 and RFRS_OVERFLOW is set.
REQ-018 IDLE with pending>0: MCU_REFRESH_STROBE SHALL toggle and the FSM SHALL go to REFRESH. Refresh has priority over REQ.
REQ-019 REFRESH: when MCU_REFRESH_ACK==MCU_REFRESH_STROBE, decrement pending and return to IDLE.
REQ-020 IDLE, pending==0, REQ!=0:
- Select the index round-robin, scanning from last+1 mod 4.
- Latch the index as cur; set last<=cur.
- Load MCU_PAGE_ADDR from slice cur.
- Toggle MCU_OPEN, clear the timeout counter, go to OPEN.
- All of this happens in the same cycle.
REQ-021 OPEN: the timeout counter SHALL increment each cycle while MCU_OPEN_ACK!=MCU_OPEN.
REQ-022 OPEN with ack match and REQ[cur]=1: GRANT[cur]<=1 on the next edge and go to HOLD. Minimum latency from REQ sampled to GRANT high is 2 cycles (ack returned in 1).
REQ-023 OPEN with ack match and REQ[cur]=0 (requester withdrew): no grant, return to IDLE.
REQ-024 OPEN timeout: when the counter reaches OPEN_TIMEOUT without an ack match:
- Set TIMEOUT_ERR and return to IDLE with no grant.
- MCU_OPEN is not re-toggled.
- While MCU_OPEN!=MCU_OPEN_ACK, IDLE SHALL NOT start a new open.
- A late ack re-enables arbitration.
REQ-025 HOLD: GRANT[cur] SHALL stay high while REQ[cur]=1. When REQ[cur]=0, GRANT<=0 and return to IDLE; arbitration resumes the next cycle.
REQ-026 REFRESH_PULSE and changes on other REQ bits SHALL NOT preempt OPEN or HOLD; refreshes accumulate in the counter.
REQ-027 GRANT SHALL never have more than one bit set, and SHALL be zero outside HOLD.
REQ-028 Toggle outputs SHALL change only on the transitions named above, at most once per cycle.

Reset
REQ-029 While RST=0 at a clock edge, the block SHALL force:
- state=IDLE, GRANT=0, MCU_PAGE_ADDR=0, MCU_OPEN=0, MCU_REFRESH_STROBE=0.
- pending=0, last=3 (requester 0 wins first), timeout counter=0, cur=0.
- BUSY=0, TIMEOUT_ERR=0, RFRS_OVERFLOW=0.
REQ-030 Reset mid-operation SHALL drop GRANT on that edge and abandon the transaction. The MCU SHALL be reset by the same RST so that the toggle pairs realign at 0.
REQ-031 Sticky flags SHALL clear only by reset.

Verification
REQ-032 Single request:
- Stimulus: REQ=0001, PAGE_ADDR[19:0]=20'hABCDE, MCU acks after 3 cycles.
- Response: MCU_PAGE_ADDR=ABCDE, MCU_OPEN toggles once, GRANT=0001 the cycle after the ack.
- Then REQ drops -> GRANT=0 next edge, BUSY=0.
REQ-033 Round-robin:
- Stimulus: REQ=1111 held, each holder releases after 5 cycles and re-raises.
- Response: grant order 0,1,2,3,0; never two GRANT bits set.
REQ-034 Refresh priority:
- Stimulus: REFRESH_PULSE and REQ=0010 in the same cycle in IDLE.
- Response: MCU_REFRESH_STROBE toggles first; GRANT[1] only after the refresh ack.
REQ-035 Refresh overflow:
- Stimulus: 4 pulses during a long HOLD.
- Response: pending=3 and RFRS_OVERFLOW=1.
- After the release, exactly 3 strobe toggles follow, each waiting for its ack.
REQ-036 Open timeout:
- Stimulus: OPEN_TIMEOUT=8'd10, no ack.
- Response: TIMEOUT_ERR=1, the FSM returns to IDLE with no grant, and no new MCU_OPEN toggle until the late ack arrives.
REQ-037 Reset during HOLD:
- Stimulus: RST=0 for 1 cycle while GRANT=0100.
- Response: all outputs take their reset values on that edge; REQ=0100 afterwards is serviced normally.
